// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - shared types and constants for the ALU command sequencer
package alu_cmd_sequencer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_SEND  = 2'd3
  } seq_state_t;

  // Compare-unit function codes issued by the system controller
  localparam logic [3:0] FUN_CMP_NOP = 4'b1000;
  localparam logic [3:0] FUN_CMP_EQ  = 4'b1001;
  localparam logic [3:0] FUN_CMP_GT  = 4'b1010;
  localparam logic [3:0] FUN_CMP_LT  = 4'b1011;

  // Counter width that stays legal when only one value is needed
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_seq_byte_ser.sv
// rtl/alu_seq_byte_ser.sv - result register and LSB-first byte serializer toward the transmitter
module alu_seq_byte_ser
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              done
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int CNT_W  = cnt_width(NBYTES);

  logic [DATA_W-1:0] result;
  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic              xfer;

  assign last = (cnt == CNT_W'(NBYTES - 1));
  assign xfer = tx_valid && !tx_busy;
  assign done = xfer && last;

  // Capture the result, then step through bytes on each accepted transfer
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      result   <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      result   <= din;
      cnt      <= '0;
      tx_valid <= 1'b1;
    end else if (xfer) begin
      if (last) begin
        tx_valid <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Present the byte selected by the counter; both sources are registers
  always_comb begin
    tx_data = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (cnt == CNT_W'(i)) begin
        tx_data = result[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - issues one ALU/compare operation and streams its result as bytes; optional WAIT timeout under ALU_SEQ_TIMEOUT_EN
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef ALU_SEQ_TIMEOUT_EN
  ,
  parameter int TMO_CYC = 15
`endif
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_fun,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              unit_en,
  output logic [3:0]        unit_fun,
  output logic [DATA_W-1:0] unit_a,
  output logic [DATA_W-1:0] unit_b,
  input  logic [DATA_W-1:0] unit_out,
  input  logic              unit_flag,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              err
);

  seq_state_t state;
  logic       load;
  logic       ser_done;
  logic       tmo_hit;

  assign cmd_ready = (state == S_IDLE);
  // Only a flag seen while waiting is a real result
  assign load      = (state == S_WAIT) && unit_flag;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_hit = (state == S_WAIT) && !unit_flag && (tmo_cnt == TMO_W'(TMO_CYC - 1));
  assign err     = err_q;

  // Count WAIT cycles; held at zero elsewhere so each WAIT starts fresh
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (state != S_WAIT || tmo_hit) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Issue/wait control with registered unit interface outputs
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      unit_en  <= 1'b0;
      unit_fun <= '0;
      unit_a   <= '0;
      unit_b   <= '0;
    end else begin
      unit_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            unit_fun <= cmd_fun;
            unit_a   <= cmd_a;
            unit_b   <= cmd_b;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          unit_en <= 1'b1;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (unit_flag) begin
            state <= S_SEND;
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (ser_done) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  alu_seq_byte_ser #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk      (clk),
    .RST      (RST),
    .load     (load),
    .din      (unit_out),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer with a compare/stub unit model
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_fun;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        unit_en;
  logic [3:0]  unit_fun;
  logic [15:0] unit_a;
  logic [15:0] unit_b;
  logic [15:0] unit_out;
  logic        unit_flag;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // unit model: 0 = compare unit, 1 = stub returning stub_val, 2 = never answers
  int          unit_mode = 0;
  logic [15:0] stub_val  = 16'h0;
  logic [15:0] unit_out_r = 16'h0;
  logic        unit_flag_r = 1'b0;
  logic        flag_force = 1'b0;

  logic [7:0] exp_q[$];
  int en_count, en_cyc, tx_seen, tx_first_cyc, tx_last_cyc, err_count, err_cyc;

  alu_cmd_sequencer dut (
    .clk       (clk),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_fun   (cmd_fun),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .unit_en   (unit_en),
    .unit_fun  (unit_fun),
    .unit_a    (unit_a),
    .unit_b    (unit_b),
    .unit_out  (unit_out),
    .unit_flag (unit_flag),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_busy   (tx_busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign unit_flag = unit_flag_r | flag_force;
  assign unit_out  = flag_force ? 16'hDEAD : unit_out_r;

  // Registered unit: answers the cycle after it samples unit_en
  always @(posedge clk) begin
    if (!RST) begin
      unit_flag_r <= 1'b0;
    end else if (unit_en && unit_mode != 2) begin
      unit_flag_r <= 1'b1;
      if (unit_mode == 1) begin
        unit_out_r <= stub_val;
      end else begin
        case (unit_fun)
          4'b1001: unit_out_r <= {15'd0, unit_a == unit_b};
          4'b1010: unit_out_r <= {15'd0, unit_a > unit_b};
          4'b1011: unit_out_r <= {15'd0, unit_a < unit_b};
          default: unit_out_r <= 16'h0;
        endcase
      end
    end else begin
      unit_flag_r <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every byte transfer
  always @(negedge clk) begin
    if (RST) begin
      if (unit_en) begin
        en_count++;
        en_cyc = cyc;
      end
      if (err) begin
        err_count++;
        err_cyc = cyc;
      end
      if (tx_valid && !tx_busy) begin
        if (tx_seen == 0) tx_first_cyc = cyc;
        tx_last_cyc = cyc;
        tx_seen++;
        if (exp_q.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
        else chk("tx_byte", tx_data, exp_q.pop_front());
      end
    end
  end

  task automatic clr_stats();
    en_count = 0; tx_seen = 0; err_count = 0;
    en_cyc = 0; tx_first_cyc = 0; tx_last_cyc = 0; err_cyc = 0;
  endtask

  task automatic send_cmd(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                          input bit push, input logic [15:0] res, output int acc);
    int n;
    cmd_fun = f; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 100);
    if (n >= 100) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    if (push) begin
      exp_q.push_back(res[7:0]);
      exp_q.push_back(res[15:8]);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, last1, fall, n, cnt;
    clr_stats();
    RST = 1'b0; cmd_valid = 1'b0; cmd_fun = 4'h0; cmd_a = 16'h0; cmd_b = 16'h0; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 RST = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_unit_en", unit_en, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;

    // EQ compare, free-running transmitter
    clr_stats();
    send_cmd(4'b1001, 16'h1234, 16'h1234, 1, 16'h0001, acc);
    wait_drain();
    chk("eq_en_count", en_count, 1);
    chk("eq_en_edges_after_accept", en_cyc + 1 - acc, 2);
    chk("eq_first_byte_latency", tx_first_cyc - acc, 3);
    chk("eq_bytes_consecutive", tx_last_cyc - tx_first_cyc, 1);
    chk("eq_byte_count", tx_seen, 2);
    chk("eq_ready_after", cmd_ready, 1);

    // GT with back-pressure
    clr_stats();
    tx_busy = 1'b1;
    send_cmd(4'b1010, 16'h0005, 16'h0003, 1, 16'h0001, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 20);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid_hold", tx_valid, 1);
      chk("bp_data_hold", tx_data, 8'h01);
    end
    @(posedge clk); #1;
    tx_busy = 1'b0;
    fall = cyc;
    wait_drain();
    chk("bp_second_after_fall", tx_last_cyc - fall, 1);
    chk("bp_byte_count", tx_seen, 2);

    // Stub result, byte order, with a spurious flag during SEND
    clr_stats();
    unit_mode = 1; stub_val = 16'hBEEF;
    tx_busy = 1'b1;
    send_cmd(4'b1000, 16'h0000, 16'h0000, 1, 16'hBEEF, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 20);
    @(posedge clk); #1 flag_force = 1'b1;
    repeat (2) @(posedge clk);
    #1 flag_force = 1'b0;
    tx_busy = 1'b0;
    wait_drain();
    chk("beef_byte_count", tx_seen, 2);

    // Spurious flag in IDLE: no capture, no transmit
    clr_stats();
    flag_force = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx_valid || !cmd_ready) cnt++;
    end
    @(posedge clk); #1 flag_force = 1'b0;
    chk("idle_flag_ignored", cnt, 0);
    chk("idle_flag_no_tx", tx_seen, 0);

    // Back-to-back commands
    unit_mode = 0;
    clr_stats();
    send_cmd(4'b1011, 16'h0003, 16'h0005, 1, 16'h0001, acc);
    send_cmd(4'b1001, 16'h0001, 16'h0002, 1, 16'h0000, acc2);
    last1 = tx_last_cyc;
    chk("b2b_accept_in_idle_cycle", acc2 - last1, 2);
    wait_drain();
    chk("b2b_byte_count", tx_seen, 4);
    chk("b2b_en_count", en_count, 2);

    // Unit never answers
    clr_stats();
    unit_mode = 2;
    send_cmd(4'b1001, 16'h0007, 16'h0007, 0, 16'h0000, acc);
`ifdef ALU_SEQ_TIMEOUT_EN
    n = 0;
    while (err_count == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_err_time", err_cyc - acc, 16);
    @(negedge clk);
    chk("tmo_err_one_cycle", err_count, 1);
    chk("tmo_back_idle", cmd_ready, 1);
    chk("tmo_no_tx", tx_seen, 0);
    @(posedge clk); #1;
    send_cmd(4'b1001, 16'h0007, 16'h0007, 0, 16'h0000, acc);
    repeat (5) @(posedge clk);
    #1;
`else
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready || err) cnt++;
    end
    chk("no_tmo_stays_busy", cnt, 0);
    @(posedge clk); #1;
`endif

    // Reset in the middle of WAIT
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_unit_en", unit_en, 0);
    chk("mid_rst_unit_a", unit_a, 0);
    chk("mid_rst_unit_fun", unit_fun, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_err", err, 0);
    @(posedge clk); #1 RST = 1'b1;
    clr_stats();
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_tx", tx_seen, 0);

    // Recovery after reset
    unit_mode = 0;
    send_cmd(4'b1010, 16'h0009, 16'h0002, 1, 16'h0001, acc);
    wait_drain();
    chk("recover_byte_count", tx_seen, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
